// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// trap_ctrl : trap entry/exit sequencer on the clint-side CSR write port.
//   Optional feature macro: TRAP_VECTORED_EN (vectored irq target).
//   Revision: 1.0
// ============================================================================
module trap_ctrl #(
  parameter logic [31:0] IRQ_CAUSE    = 32'h8000_000B,
  parameter logic [31:0] ECALL_CAUSE  = 32'd11,
  parameter logic [31:0] EBREAK_CAUSE = 32'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_ecall_i,
  input  logic        inst_ebreak_i,
  input  logic        inst_mret_i,
  input  logic [31:0] inst_addr_i,
  input  logic        irq_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        hold_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE            = 3'd0,
    S_WR_MEPC         = 3'd1,
    S_WR_MSTATUS      = 3'd2,
    S_WR_MCAUSE       = 3'd3,
    S_JUMP            = 3'd4,
    S_MRET_WR_MSTATUS = 3'd5,
    S_MRET_JUMP       = 3'd6
  } state_t;

  localparam logic [31:0] c_csr_mstatus = 32'h300;
  localparam logic [31:0] c_csr_mepc    = 32'h341;
  localparam logic [31:0] c_csr_mcause  = 32'h342;

  state_t      state_q, state_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic        irq_take;
  logic        event_any;
  logic [31:0] trap_base;
  logic [31:0] trap_target;
  logic [31:0] mstatus_trap;
  logic [31:0] mstatus_mret;

  assign irq_take  = irq_i & mstatus_i[3] & mie_i[11];
  assign event_any = inst_ecall_i | inst_ebreak_i | inst_mret_i | irq_take;
  assign trap_base = {mtvec_i[31:2], 2'b00};

  // MPIE <- MIE, MIE <- 0 on entry; MIE <- MPIE, MPIE <- 1 on return.
  always_comb begin
    mstatus_trap    = mstatus_i;
    mstatus_trap[7] = mstatus_i[3];
    mstatus_trap[3] = 1'b0;
    mstatus_mret    = mstatus_i;
    mstatus_mret[3] = mstatus_i[7];
    mstatus_mret[7] = 1'b1;
  end

`ifdef TRAP_VECTORED_EN
  // Interrupt causes have bit 31 set; only those are vectored.
  assign trap_target = (cause_q[31] && (mtvec_i[1:0] == 2'b01))
                     ? trap_base + {cause_q[29:0], 2'b00}
                     : trap_base;
  logic unused_mie;
  assign unused_mie = ^{mie_i[31:12], mie_i[10:0]};
`else
  assign trap_target = trap_base;
  logic unused_mie;
  assign unused_mie = ^{mie_i[31:12], mie_i[10:0], mtvec_i[1:0]};
`endif

  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    hold_o  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        hold_o = rst_n & event_any;
        if (inst_ecall_i) begin
          state_d = S_WR_MEPC;
          epc_d   = inst_addr_i;
          cause_d = ECALL_CAUSE;
        end else if (inst_ebreak_i) begin
          state_d = S_WR_MEPC;
          epc_d   = inst_addr_i;
          cause_d = EBREAK_CAUSE;
        end else if (inst_mret_i) begin
          state_d = S_MRET_WR_MSTATUS;
        end else if (irq_take) begin
          state_d = S_WR_MEPC;
          epc_d   = inst_addr_i;
          cause_d = IRQ_CAUSE;
        end
      end
      S_WR_MEPC:         state_d = S_WR_MSTATUS;
      S_WR_MSTATUS:      state_d = S_WR_MCAUSE;
      S_WR_MCAUSE:       state_d = S_JUMP;
      S_JUMP:            state_d = S_IDLE;
      S_MRET_WR_MSTATUS: state_d = S_MRET_JUMP;
      S_MRET_JUMP:       state_d = S_IDLE;
      default:           state_d = S_IDLE;
    endcase
  end

  // Write port and redirect are decoded from the state register only.
  always_comb begin
    csr_we_o    = 1'b0;
    csr_waddr_o = 32'h0;
    csr_wdata_o = 32'h0;
    jump_flag_o = 1'b0;
    jump_addr_o = 32'h0;
    case (state_q)
      S_WR_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = c_csr_mepc;
        csr_wdata_o = epc_q;
      end
      S_WR_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = c_csr_mstatus;
        csr_wdata_o = mstatus_trap;
      end
      S_WR_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = c_csr_mcause;
        csr_wdata_o = cause_q;
      end
      S_JUMP: begin
        jump_flag_o = 1'b1;
        jump_addr_o = trap_target;
      end
      S_MRET_WR_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = c_csr_mstatus;
        csr_wdata_o = mstatus_mret;
      end
      S_MRET_JUMP: begin
        jump_flag_o = 1'b1;
        jump_addr_o = mepc_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      epc_q   <= 32'h0;
      cause_q <= 32'h0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// tb_trap_ctrl : scoreboard bench for trap_ctrl with a behavioural model.
//   Revision: 1.0
// ============================================================================
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_ecall_i = 1'b0, inst_ebreak_i = 1'b0, inst_mret_i = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic        irq_i = 1'b0;
  logic [31:0] mtvec_i = '0, mepc_i = '0, mstatus_i = '0, mie_i = '0;
  logic        csr_we_o, hold_o, jump_flag_o;
  logic [31:0] csr_waddr_o, csr_wdata_o, jump_addr_o;

  trap_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .inst_ecall_i(inst_ecall_i), .inst_ebreak_i(inst_ebreak_i),
    .inst_mret_i(inst_mret_i), .inst_addr_i(inst_addr_i), .irq_i(irq_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i), .mstatus_i(mstatus_i), .mie_i(mie_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .hold_o(hold_o), .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_jump;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe on the write port or redirect pops one expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (csr_we_o || jump_flag_o) begin
        exp_t e;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: we=%0b jump=%0b addr=%h data=%h jaddr=%h, required none",
                   csr_we_o, jump_flag_o, csr_waddr_o, csr_wdata_o, jump_addr_o);
        end else begin
          e = q.pop_front();
          if (e.is_jump) begin
            if (!jump_flag_o || csr_we_o || jump_addr_o !== e.data || cyc != e.cyc) begin
              errors++;
              $display("FAIL jump: got flag=%0b we=%0b addr=%h cyc=%0d, required addr=%h cyc=%0d",
                       jump_flag_o, csr_we_o, jump_addr_o, cyc, e.data, e.cyc);
            end
          end else begin
            if (!csr_we_o || jump_flag_o || csr_waddr_o !== e.addr ||
                csr_wdata_o !== e.data || cyc != e.cyc) begin
              errors++;
              $display("FAIL csr_write: got we=%0b waddr=%h wdata=%h cyc=%0d, required waddr=%h wdata=%h cyc=%0d",
                       csr_we_o, csr_waddr_o, csr_wdata_o, cyc, e.addr, e.data, e.cyc);
            end
          end
        end
      end else begin
        checks++;
        if (csr_waddr_o !== 32'h0 || csr_wdata_o !== 32'h0 || jump_addr_o !== 32'h0) begin
          errors++;
          $display("FAIL idle_zero: got waddr=%h wdata=%h jaddr=%h, required all 0",
                   csr_waddr_o, csr_wdata_o, jump_addr_o);
        end
      end
    end
  end

  task automatic check_hold(input string name, input logic exp);
    checks++;
    if (hold_o !== exp) begin
      errors++;
      $display("FAIL %s: hold_o=%b required %b", name, hold_o, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({csr_we_o, hold_o, jump_flag_o} !== 3'b0 || csr_waddr_o !== 32'h0 ||
        csr_wdata_o !== 32'h0 || jump_addr_o !== 32'h0) begin
      errors++;
      $display("FAIL %s: we=%b hold=%b jump=%b waddr=%h wdata=%h jaddr=%h, required all 0",
               name, csr_we_o, hold_o, jump_flag_o, csr_waddr_o, csr_wdata_o, jump_addr_o);
    end
  endtask

  // Reference model: trap entry redirect target.
  function automatic logic [31:0] model_target(input logic [31:0] tv, input logic [31:0] cause,
                                               input bit is_irq);
    logic [31:0] base;
    base = tv & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
    if (is_irq && (tv & 32'h3) == 32'h1) return base + (cause & 32'h7FFF_FFFF) * 4;
`endif
    if (is_irq) return base;
    return base;
  endfunction

  function automatic exp_t mk(input bit j, input logic [31:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.is_jump = j; e.addr = a; e.data = d; e.cyc = c;
    return e;
  endfunction

  task automatic do_txn(input logic e, input logic b, input logic m, input logic i,
                        input logic [31:0] addr, input logic [31:0] ms, input logic [31:0] mi,
                        input logic [31:0] tv, input logic [31:0] ep);
    bit          irq_ok, take, is_mret, is_irq;
    logic [31:0] cause, ms_exp;
    int          n, c;
    @(negedge clk);
    inst_ecall_i = e; inst_ebreak_i = b; inst_mret_i = m; irq_i = i;
    inst_addr_i = addr; mstatus_i = ms; mie_i = mi; mtvec_i = tv; mepc_i = ep;
    #1;
    c       = cyc;
    irq_ok  = i && ms[3] && mi[11];
    take    = e || b || m || irq_ok;
    is_mret = !e && !b && m;
    is_irq  = !e && !b && !m && irq_ok;
    cause   = e ? 32'd11 : (b ? 32'd3 : 32'h8000_000B);
    check_hold("hold_accept", take);
    n = 0;
    if (take && is_mret) begin
      ms_exp = (ms & ~32'h88) | 32'h80 | (ms[7] ? 32'h8 : 32'h0);
      q.push_back(mk(0, 32'h300, ms_exp, c + 1));
      q.push_back(mk(1, 32'h0, ep, c + 2));
      n = 2;
    end else if (take) begin
      ms_exp = (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0);
      q.push_back(mk(0, 32'h341, addr, c + 1));
      q.push_back(mk(0, 32'h300, ms_exp, c + 2));
      q.push_back(mk(0, 32'h342, cause, c + 3));
      q.push_back(mk(1, 32'h0, model_target(tv, cause, is_irq), c + 4));
      n = 4;
    end
    @(negedge clk);
    inst_ecall_i = 0; inst_ebreak_i = 0; inst_mret_i = 0; irq_i = 0;
    for (int k = 1; k <= n; k++) begin
      #1 check_hold("hold_busy", 1'b1);
      @(negedge clk);
    end
    #1 check_hold("hold_done", 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    #2 rst_n = 1'b1;

    // Directed cases.
    do_txn(1, 0, 0, 0, 32'h100, 32'h8, 32'h0, 32'h200, 32'h0);
    do_txn(0, 0, 0, 1, 32'h40, 32'h8, 32'h800, 32'h200, 32'h0);
    do_txn(0, 0, 0, 1, 32'h40, 32'h8, 32'h0, 32'h200, 32'h0);
    do_txn(0, 0, 1, 0, 32'h0, 32'h80, 32'h0, 32'h200, 32'h44);
    do_txn(1, 0, 0, 1, 32'h80, 32'h8, 32'h800, 32'h200, 32'h0);
    do_txn(0, 0, 0, 1, 32'h84, 32'h0, 32'h800, 32'h200, 32'h0);
    do_txn(0, 1, 1, 1, 32'h90, 32'h8, 32'h800, 32'h300, 32'h0);
    do_txn(0, 0, 0, 1, 32'h40, 32'h8, 32'h800, 32'h201, 32'h0);
    do_txn(0, 0, 0, 1, 32'h40, 32'h8, 32'h800, 32'hFFFF_FFF1, 32'h0);
    do_txn(1, 0, 0, 0, 32'h40, 32'h8, 32'h800, 32'h201, 32'h0);

    // Reset in the middle of an ecall entry.
    @(negedge clk);
    inst_ecall_i = 1; inst_addr_i = 32'h100; mstatus_i = 32'h8; mtvec_i = 32'h200;
    #1;
    q.push_back(mk(0, 32'h341, 32'h100, cyc + 1));
    q.push_back(mk(0, 32'h300, 32'h80, cyc + 2));
    @(negedge clk);
    inst_ecall_i = 0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_seq");
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1 check_hold("hold_after_reset", 1'b0);

    // Randomized transactions.
    for (int t = 0; t < 60; t++) begin
      logic e, b, m, i;
      logic [31:0] ms, mi, tv;
      e  = ($urandom_range(0, 5) == 0);
      b  = ($urandom_range(0, 5) == 0);
      m  = ($urandom_range(0, 4) == 0);
      i  = $urandom_range(0, 1);
      ms = $urandom; ms[3] = ($urandom_range(0, 3) != 0);
      mi = $urandom; mi[11] = ($urandom_range(0, 3) != 0);
      tv = $urandom; tv[1:0] = 2'($urandom_range(0, 3));
      do_txn(e, b, m, i, $urandom, ms, mi, tv, $urandom);
    end

    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d outstanding, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap-entry/exit sequencer that drives the CSR block's clint-side write port (clint_we/waddr/wdata) and reads back mtvec/mepc/mstatus/mie.
- On ecall, ebreak or a gated external interrupt it stalls the pipeline, writes mepc, mstatus and mcause one per cycle, then redirects fetch to the trap vector.
- On mret it restores mstatus and redirects to mepc.

Parameters:
- IRQ_CAUSE, 32'h8000_000B, mcause value written for an external interrupt.
- ECALL_CAUSE, 32'd11, mcause value written for ecall.
- EBREAK_CAUSE, 32'd3, mcause value written for ebreak.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- inst_ecall_i  in  1  exu is executing ecall (1-cycle pulse)
- inst_ebreak_i  in  1  exu is executing ebreak (1-cycle pulse)
- inst_mret_i  in  1  exu is executing mret (1-cycle pulse)
- inst_addr_i  in  32  PC of the instruction currently in exu
- irq_i  in  1  external interrupt request, level
- mtvec_i  in  32  mtvec from csr_reg
- mepc_i  in  32  mepc from csr_reg
- mstatus_i  in  32  mstatus from csr_reg
- mie_i  in  32  mie from csr_reg
- csr_we_o  out  1  CSR write enable (to clint_we_i)
- csr_waddr_o  out  32  CSR write address
- csr_wdata_o  out  32  CSR write data
- hold_o  out  1  pipeline stall request
- jump_flag_o  out  1  fetch redirect strobe
- jump_addr_o  out  32  redirect target

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. State=IDLE; every output 0; captured epc/cause registers 0.
- Events sampled only in IDLE. Priority: ecall > ebreak > mret > irq.
- irq is taken only when irq_i=1 AND mstatus_i[3] (MIE)=1 AND mie_i[11] (MEIE)=1.
- Accept cycle T:
  - hold_o=1 combinationally in T (the only input-to-output path).
  - Capture epc=inst_addr_i; capture cause (ECALL_CAUSE, EBREAK_CAUSE or IRQ_CAUSE).
- Entry states:
  - T+1 WR_MEPC: we=1, waddr=32'h341, wdata=epc.
  - T+2 WR_MSTATUS: we=1, waddr=32'h300, wdata=mstatus_i with bit7=mstatus_i[3] and bit3=0. Computed from live mstatus_i this cycle; all other bits pass through.
  - T+3 WR_MCAUSE: we=1, waddr=32'h342, wdata=cause.
  - T+4 JUMP: we=0, jump_flag_o=1, jump_addr_o={mtvec_i[31:2],2'b00}.
  - T+5: IDLE.
- mret path:
  - T+1 MRET_WR_MSTATUS: we=1, waddr=32'h300, wdata=mstatus_i with bit3=mstatus_i[7] and bit7=1.
  - T+2 MRET_JUMP: jump_flag_o=1, jump_addr_o=mepc_i.
  - T+3: IDLE.
- hold_o=1 in every non-IDLE state, including JUMP/MRET_JUMP. Because csr_reg gives exu writes priority, hold_o guarantees exu issues no CSR write while the sequencer writes.
- csr_*, jump_* outputs are decoded from the state register only. Address/data are 0 whenever we=0; jump_addr_o is 0 when jump_flag_o=0.
- Events arriving while not IDLE are ignored (exu is held, so no new pulses occur).
- irq_i still high at return to IDLE is not retaken, since MIE is now 0.
- Reset mid-sequence: immediate return to IDLE, outputs 0. Partially written CSRs are not rolled back.

Optional Feature:
- Macro: TRAP_VECTORED_EN.
- Defined: for irq entries with mtvec_i[1:0]==2'b01, jump_addr_o={mtvec_i[31:2],2'b00} + (cause[30:0]<<2). Arithmetic is 32-bit and wraps modulo 2^32. Exceptions and mode 2'b00 always use the base address.
- Undefined: always base address; mtvec_i[1:0] ignored.

Test Plan:
- ecall at inst_addr_i=0x100, mstatus_i=0x8, mtvec_i=0x200 -> writes 0x341←0x100, 0x300←0x80, 0x342←11 in T+1..T+3; jump_addr_o=0x200 at T+4; hold_o 1 for T..T+4.
- irq_i=1 with mstatus_i=0x8, mie_i=0x800, inst_addr_i=0x40 -> mcause 0x8000_000B, mepc 0x40. Same stimulus with mie_i=0 -> no write, hold_o stays 0.
- mret with mstatus_i=0x80, mepc_i=0x44 -> 0x300←0x88 at T+1; jump_addr_o=0x44 at T+2; IDLE at T+3.
- ecall and irq_i asserted in the same cycle -> mcause=11; irq taken only if MIE is re-enabled later.
- rst_n pulsed low at T+2 of an ecall entry -> all outputs 0 immediately; no mcause write follows.
- With TRAP_VECTORED_EN, mtvec_i=0x201, irq -> jump_addr_o=0x200+0x2C=0x22C. Without the macro -> 0x200.
